// File: rtl/pipe_stage_buf.sv
// Pipeline-stage buffer with a valid/ready handshake, an optional two-entry skid,
// a flush that loads the bubble word, and a saturating stall-cycle counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | nothing held; main = BUBBLE, o_valid = 0
// FULL  | one word in main, presented downstream
// SKID2 | main presented, a second word waits in skid (SKID=1 only)
module pipe_stage_buf #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int               SKID   = 1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic [CNT_W-1:0] stall_q;
    logic             stall;

    assign o_valid     = (state != EMPTY);
    assign o_data      = main_q;
    assign o_stall_cnt = stall_q;
    assign stall       = o_valid & ~i_ready;

    // With the skid entry, ready comes straight from state so i_ready never reaches it.
    always_comb begin
        if (SKID != 0) begin
            o_ready = (state != SKID2);
        end else begin
            o_ready = ~o_valid | i_ready;
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (i_valid) begin
                        state_nxt = FULL;
                        main_nxt  = i_data;
                    end
                end
                FULL: begin
                    if (i_ready) begin
                        if (i_valid) begin
                            main_nxt = i_data;
                        end else begin
                            state_nxt = EMPTY;
                            main_nxt  = BUBBLE;
                        end
                    end else if (i_valid && (SKID != 0)) begin
                        state_nxt = SKID2;
                        skid_nxt  = i_data;
                    end
                end
                SKID2: begin
                    if (i_ready) begin
                        state_nxt = FULL;
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = BUBBLE;
                    skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Counts the flush cycle too; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (skid, no-skid, 2-bit counter) share
// stimulus and are checked every cycle against a FIFO-occupancy model.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        flush = 1'b0;
    logic        i_ready = 1'b0;

    logic        o_ready_s, o_valid_s;
    logic [31:0] o_data_s;
    logic [15:0] cnt_s;
    logic        o_ready_n, o_valid_n;
    logic [31:0] o_data_n;
    logic [15:0] cnt_n;
    logic        o_ready_t, o_valid_t;
    logic [31:0] o_data_t;
    logic [1:0]  cnt_t;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_s), .i_data(i_data),
        .flush(flush), .o_valid(o_valid_s), .i_ready(i_ready), .o_data(o_data_s),
        .o_stall_cnt(cnt_s));

    pipe_stage_buf #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_n), .i_data(i_data),
        .flush(flush), .o_valid(o_valid_n), .i_ready(i_ready), .o_data(o_data_n),
        .o_stall_cnt(cnt_n));

    pipe_stage_buf #(.WIDTH(32), .SKID(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_t), .i_data(i_data),
        .flush(flush), .o_valid(o_valid_t), .i_ready(i_ready), .o_data(o_data_t),
        .o_stall_cnt(cnt_t));

    // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid) plus a counter.
    int          mn[3] = '{0, 0, 0};
    logic [31:0] mq[3][2];
    longint      mc[3] = '{0, 0, 0};

    function automatic bit is_skid(int k);
        return k != 1;
    endfunction

    function automatic longint cmax(int k);
        return (k == 2) ? 64'd3 : 64'd65535;
    endfunction

    function automatic bit m_ready(int k);
        if (is_skid(k)) return mn[k] < 2;
        return (mn[k] == 0) || i_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mn[k] = 0;
                mc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit acc;
                acc = i_valid && m_ready(k);
                if (mn[k] > 0 && !i_ready && mc[k] < cmax(k)) mc[k] = mc[k] + 1;
                if (flush) begin
                    mn[k] = 0;
                end else begin
                    if (mn[k] > 0 && i_ready) begin
                        mq[k][0] = mq[k][1];
                        mn[k] = mn[k] - 1;
                    end
                    if (acc) begin
                        mq[k][mn[k]] = i_data;
                        mn[k] = mn[k] + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input string tag, input logic v, input logic [31:0] d,
                            input logic r, input logic [15:0] c);
        check({tag, ".o_valid"}, 64'(v), 64'(mn[k] > 0));
        check({tag, ".o_data"}, 64'(d), 64'((mn[k] > 0) ? mq[k][0] : 32'h0));
        check({tag, ".o_ready"}, 64'(r), 64'(m_ready(k)));
        check({tag, ".o_stall_cnt"}, 64'(c), 64'(mc[k]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, "skid", o_valid_s, o_data_s, o_ready_s, cnt_s);
        cmp_inst(1, "noskid", o_valid_n, o_data_n, o_ready_n, cnt_n);
        cmp_inst(2, "sat", o_valid_t, o_data_t, o_ready_t, {14'd0, cnt_t});
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        flush   = f;
        #2;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " rst o_valid_s"}, 64'(o_valid_s), 64'd0);
        check({tag, " rst o_data_s"}, 64'(o_data_s), 64'd0);
        check({tag, " rst o_ready_s"}, 64'(o_ready_s), 64'd1);
        check({tag, " rst cnt_s"}, 64'(cnt_s), 64'd0);
        check({tag, " rst cnt_t"}, 64'(cnt_t), 64'd0);
    endtask

    logic [1:0] sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2 chk_reset("initial");

        // streaming
        cyc(1'b1, 32'hA1, 1'b1, 1'b0);
        check("stream ready0", 64'(o_ready_s), 64'd1);
        cyc(1'b1, 32'hA2, 1'b1, 1'b0);
        check("stream d1", 64'(o_data_s), 64'hA1);
        check("stream ready1", 64'(o_ready_s), 64'd1);
        cyc(1'b1, 32'hA3, 1'b1, 1'b0);
        check("stream d2", 64'(o_data_s), 64'hA2);
        check("stream d2 noskid", 64'(o_data_n), 64'hA2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream d3", 64'(o_data_s), 64'hA3);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream drained", 64'(o_valid_s), 64'd0);

        // backpressure
        cyc(1'b1, 32'hA1, 1'b1, 1'b0);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        check("bp held A1", 64'(o_data_s), 64'hA1);
        check("bp skid ready late", 64'(o_ready_s), 64'd1);
        check("bp noskid ready same", 64'(o_ready_n), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("bp skid2 ready", 64'(o_ready_s), 64'd0);
        check("bp skid2 data", 64'(o_data_s), 64'hA1);
        check("bp noskid data", 64'(o_data_n), 64'hA1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp noskid ready back", 64'(o_ready_n), 64'd1);
        check("bp deliver A1", 64'(o_data_s), 64'hA1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp deliver A2", 64'(o_data_s), 64'hA2);
        check("bp noskid dropped A2", 64'(o_valid_n), 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp empty", 64'(o_valid_s), 64'd0);

        // flush while SKID2 holds A1/A2 and A3 is offered
        cyc(1'b1, 32'hA1, 1'b1, 1'b0);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        cyc(1'b1, 32'hA3, 1'b0, 1'b1);
        check("flush pre data", 64'(o_data_s), 64'hA1);
        check("flush pre ready", 64'(o_ready_s), 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("flush valid", 64'(o_valid_s), 64'd0);
        check("flush data", 64'(o_data_s), 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("flush stays empty", 64'(o_valid_s), 64'd0);

        // asynchronous reset mid-operation
        cyc(1'b1, 32'hA5, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("pre-rst valid", 64'(o_valid_s), 64'd1);
        rst = 1'b1;
        #1 chk_reset("async");
        @(posedge clk);
        #1 rst = 1'b0;

        // stall counter saturation (2-bit)
        cyc(1'b1, 32'hB1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("sat start", 64'(cnt_t), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0);
            check($sformatf("sat cnt %0d", i), 64'(cnt_t), 64'(sat_exp[i]));
            check($sformatf("sat valid %0d", i), 64'(o_valid_t), 64'd1);
        end
        rst = 1'b1;
        #1 check("sat after rst", 64'(cnt_t), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            rst     = ($urandom_range(0, 499) == 0);
            i_valid = ($urandom_range(0, 2) != 0);
            i_data  = $urandom;
            i_ready = (n % 400 < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid = 1'b0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
